// File: rtl/morse_tx.sv
// Morse keyer: takes one 6-bit character per valid/ready handshake and keys it out on key_out
// as timed marks and gaps measured in UNIT_CYCLES-long time units.
module morse_tx #(
    parameter int unsigned UNIT_CYCLES = 12_000_000,
    parameter int unsigned MAX_LEN     = 5
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [5:0] char_data,
    input  logic [2:0] char_len,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy
);

    localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] UnitLast = CW'(UNIT_CYCLES - 1);
    localparam logic [2:0] MaxLen = 3'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StMark    = 3'd1,
        StElemGap = 3'd2,
        StCharGap = 3'd3,
        StWordGap = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    units_q, units_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    data_q, data_d;
    logic [2:0]    len_q, len_d;

    logic       tick;
    logic       done;
    logic       accept;
    logic       cur_dash;
    logic [2:0] units_last;
    logic [2:0] len_clamp;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        units_d  = units_q;
        idx_d    = idx_q;
        data_d   = data_q;
        len_d    = len_q;

        tick      = (cnt_q == UnitLast);
        cur_dash  = data_q[idx_q];
        accept    = char_valid && char_ready;
        len_clamp = (char_len > MaxLen) ? MaxLen : char_len;

        // Index of the final time unit of the current state.
        case (state_q)
            StMark:    units_last = cur_dash ? 3'd2 : 3'd0;
            StCharGap: units_last = 3'd2;
            StWordGap: units_last = 3'd6;
            default:   units_last = 3'd0;
        endcase
        done = tick && (units_q == units_last);

        if (state_q != StIdle) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                units_d = units_q + 3'd1;
            end
        end

        case (state_q)
            StIdle: begin
                cnt_d   = '0;
                units_d = '0;
                if (accept) begin
                    data_d = char_data;
                    len_d  = len_clamp;
                    idx_d  = '0;
                    if (char_data[5]) begin
                        state_d = StWordGap;
                    end else if (len_clamp == 3'd0) begin
                        state_d = StCharGap;
                    end else begin
                        state_d = StMark;
                    end
                end
            end
            StMark: begin
                if (done) begin
                    units_d = '0;
                    idx_d   = idx_q + 3'd1;
                    state_d = (idx_q == len_q - 3'd1) ? StCharGap : StElemGap;
                end
            end
            StElemGap: begin
                if (done) begin
                    units_d = '0;
                    state_d = StMark;
                end
            end
            StCharGap, StWordGap: begin
                if (done) begin
                    units_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                units_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            units_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            units_q <= units_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            len_q   <= len_d;
        end
    end

    // Outputs are registered decodes of the next state so they line up with state_q.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            char_ready <= 1'b0;
            key_out    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            char_ready <= (state_d == StIdle);
            key_out    <= (state_d == StMark);
            busy       <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: directed and random characters compared cycle by cycle against a
// keying waveform built from the Morse timing rules.
module tb_morse_tx;

    localparam int unsigned U = 4;

    logic       clk_100MHz;
    logic       reset;
    logic [5:0] char_data;
    logic [2:0] char_len;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    morse_tx #(
        .UNIT_CYCLES(U),
        .MAX_LEN    (5)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .char_data (char_data),
        .char_len  (char_len),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .key_out   (key_out),
        .busy      (busy)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
        end
    endtask

    // Expected key_out for every busy cycle of one character.
    function automatic void build(input logic [5:0] d, input logic [2:0] l);
        int n;
        exp_q.delete();
        if (d[5]) begin
            for (int i = 0; i < 7 * U; i++) exp_q.push_back(1'b0);
            return;
        end
        n = (l > 5) ? 5 : int'(l);
        for (int e = 0; e < n; e++) begin
            for (int i = 0; i < (d[e] ? 3 : 1) * U; i++) exp_q.push_back(1'b1);
            if (e < n - 1) for (int i = 0; i < U; i++) exp_q.push_back(1'b0);
        end
        for (int i = 0; i < 3 * U; i++) exp_q.push_back(1'b0);
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (char_ready !== 1'b1 && waited < 200) begin
            @(negedge clk_100MHz);
            waited++;
        end
        chk("ready_wait", char_ready, 1'b1);
    endtask

    // Called on a negedge; hold keeps char_valid high with junk data while busy.
    task automatic send(input logic [5:0] d, input logic [2:0] l, input bit hold);
        wait_ready();
        char_data  = d;
        char_len   = l;
        char_valid = 1'b1;
        build(d, l);
        @(negedge clk_100MHz);
        if (!hold) char_valid = 1'b0;
        foreach (exp_q[i]) begin
            chk("key_out", key_out, exp_q[i]);
            chk("busy_hi", busy, 1'b1);
            chk("ready_lo", char_ready, 1'b0);
            if (hold) begin
                char_data = 6'($urandom_range(0, 63));
                char_len  = 3'($urandom_range(0, 7));
            end
            @(negedge clk_100MHz);
        end
        chk("ready_back", char_ready, 1'b1);
        chk("busy_lo", busy, 1'b0);
        chk("key_idle", key_out, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        char_data  = '0;
        char_len   = '0;
        char_valid = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        chk("rst_ready", char_ready, 1'b0);
        chk("rst_key", key_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk_100MHz);
        chk("ready_after_rst", char_ready, 1'b1);

        send(6'b000000, 3'd1, 1'b0);     // E
        send(6'b000010, 3'd2, 1'b0);     // A
        send(6'b100000, 3'd3, 1'b0);     // space, len ignored
        send(6'b011111, 3'd7, 1'b0);     // clamped to five dashes
        send(6'b000000, 3'd0, 1'b0);     // empty char: gap only

        // Reset in the middle of a dash of 'T'.
        wait_ready();
        char_data  = 6'b000001;
        char_len   = 3'd1;
        char_valid = 1'b1;
        @(negedge clk_100MHz);
        char_valid = 1'b0;
        repeat (5) begin
            chk("t_mark", key_out, 1'b1);
            @(negedge clk_100MHz);
        end
        reset = 1'b1;
        @(negedge clk_100MHz);
        chk("midrst_key", key_out, 1'b0);
        chk("midrst_ready", char_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clk_100MHz);
        chk("midrst_resume", char_ready, 1'b1);
        send(6'b000000, 3'd1, 1'b0);     // E after reset

        // Valid held with changing data while busy; back-to-back chars.
        send(6'b000110, 3'd3, 1'b1);
        send(6'b000101, 3'd4, 1'b1);
        send(6'b000001, 3'd2, 1'b0);

        for (int k = 0; k < 10; k++) begin
            logic [5:0] d;
            logic [2:0] l;
            d = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) d[5] = 1'b0;
            l = 3'($urandom_range(0, 7));
            send(d, l, k != 9 && $urandom_range(0, 1) == 1);
        end
        char_valid = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        chk("final_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
